aud_i2s_recorder: RTL and testbench
===================================

// Module: aud_i2s_recorder
// PURPOSE
//  Deserialises the WM8731 I2S ADC stream (left channel only) into 16-bit samples.
//  Emits one SRAM write request per sample, with an auto-incrementing address.
//  Sits between the codec pins (AUD_BCLK/AUD_ADCLRCK/AUD_ADCDAT) and the SRAM write port inside Top.
//  Record/pause/stop requests arrive as debounced one-cycle pulses from the key path.
// PARAMETERS
//  ADDR_W    20            SRAM word-address width
//  DATA_W    16            sample width; bits shifted per frame
//  MAX_ADDR  20'hFFFFF     last writable address; a write here ends recording
// PORTS
//  i_clk      in   1       AUD_BCLK (codec bit clock); all logic on posedge
//  i_rst      in   1       async active-high reset
//  i_start    in   1       pulse: begin new recording (from IDLE) / resume (from PAUSE)
//  i_pause    in   1       pulse: pause after current sample completes
//  i_stop     in   1       pulse: abort immediately, return to IDLE
//  i_lrc      in   1       AUD_ADCLRCK; low = left channel
//  i_adcdat   in   1       AUD_ADCDAT serial data, MSB first
//  o_address  out  ADDR_W  current write address (= samples written so far)
//  o_data     out  DATA_W  last assembled sample
//  o_valid    out  1       one-cycle SRAM write strobe for o_address/o_data
//  o_recording out 1       high in ARM, SHIFT, WRITE
//  o_full     out  1       set when MAX_ADDR has been written; sticky until next start
// BEHAVIOUR
//  Reset values: o_address=0, o_data=0, o_valid=0, o_recording=0, o_full=0.
//   Reset also forces state=IDLE, shift reg=0, bit cnt=0, lrc_q=1, pause_req=0.
//  lrc_q registers i_lrc every cycle. lrc_fall = lrc_q & ~i_lrc (same cycle).
//  States: IDLE, ARM, SHIFT, WRITE, PAUSE.
//  IDLE:  i_start -> ARM; address<=0; o_full<=0.
//  ARM:   wait for lrc_fall -> SHIFT with cnt<=0. The detect cycle carries no data
//         (I2S 1-bit delay).
//  SHIFT: each cycle sr<={sr[DATA_W-2:0],i_adcdat}; cnt++.
//         At cnt==DATA_W-1: o_data<={sr[DATA_W-2:0],i_adcdat}; -> WRITE.
//  WRITE: o_valid=1 for exactly this cycle; o_address is the sample's address.
//         If address==MAX_ADDR: o_full<=1, address held, -> IDLE.
//         Else address<=address+1, then:
//           pause_req set     -> PAUSE, clear pause_req
//           pause_req clear   -> ARM
//  Latency: o_valid is asserted DATA_W+1 cycles after the lrc_fall detect cycle.
//  PAUSE: address/o_data held; i_start -> ARM. A new LRC fall is required, so no
//         partial frame is ever captured.
//  Right-channel half (i_lrc high) is ignored. LRC activity in IDLE/PAUSE is ignored.
//  i_pause:
//    In ARM: -> PAUSE at once.
//    In SHIFT/WRITE: sets pause_req; the current sample still completes and writes.
//    In IDLE/PAUSE: no effect.
//  i_stop (any state): -> IDLE next cycle; partial sample discarded; o_valid=0.
//    address and o_data retained; pause_req cleared.
//  Simultaneous pulses, priority stop > pause > start.
//    In WRITE, the stop still lets this cycle's o_valid occur.
//  i_start while ARM/SHIFT/WRITE: ignored (no restart).
//  o_address wrap-around is impossible: the counter saturates at MAX_ADDR via the full path.
//  Async reset mid-SHIFT: outputs return to reset values immediately; no o_valid is emitted.
// TESTING
//  T1 Reset: assert i_rst with random inputs -> all outputs 0, no o_valid for 100 cycles.
//  T2 Single sample: start, then drive an I2S left frame of 16'hA5C3
//     -> one o_valid, o_address=0, o_data=16'hA5C3, 17 cycles after the LRC fall.
//  T3 Stream: 3 frames 16'h0001, 16'h8000, 16'hFFFF
//     -> writes at addresses 0,1,2 in order; right-half data never appears.
//  T4 Pause: pause pulse at bit 5 of frame 2 -> frame 2 written (addr 1), then no writes
//     for 5 frames; start -> next write at addr 2.
//  T5 Stop: stop pulse at bit 8 of frame 1 -> no o_valid, o_recording=0, o_address stays 0.
//     Start again -> address restarts at 0.
//  T6 Full: MAX_ADDR=3, 6 frames -> writes at addr 0..3 only, o_full=1 after the 4th.
//     A subsequent start clears o_full and writes addr 0.

Source files
------------

// File: rtl/aud_i2s_recorder.sv
// Captures the left channel of a WM8731 I2S ADC stream as DATA_W-bit samples.
// Each sample produces one SRAM write strobe at an address that increments per sample.
module aud_i2s_recorder #(
    parameter int unsigned       ADDR_W   = 20,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_lrc,
    input  logic              i_adcdat,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_recording,
    output logic              o_full
);
    localparam int unsigned      CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {StIdle, StArm, StShift, StWrite, StPause} state_e;

    state_e            r_state;
    logic [DATA_W-1:0] r_sr;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_address;
    logic              r_lrc_q;
    logic              r_pause_req;
    logic              r_valid;
    logic              r_recording;
    logic              r_full;

    logic              w_lrc_fall;
    logic [DATA_W-1:0] w_sr_next;

    // The cycle that detects the fall carries the previous right-channel LSB (I2S 1-bit delay).
    assign w_lrc_fall = r_lrc_q & ~i_lrc;
    assign w_sr_next  = {r_sr[DATA_W-2:0], i_adcdat};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_sr        <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_address   <= '0;
            r_lrc_q     <= 1'b1;
            r_pause_req <= 1'b0;
            r_valid     <= 1'b0;
            r_recording <= 1'b0;
            r_full      <= 1'b0;
        end else begin
            r_lrc_q <= i_lrc;
            r_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start && !i_stop && !i_pause) begin
                        r_state     <= StArm;
                        r_address   <= '0;
                        r_full      <= 1'b0;
                        r_recording <= 1'b1;
                    end
                end
                StArm: begin
                    if (i_stop) begin
                        r_state     <= StIdle;
                        r_recording <= 1'b0;
                        r_pause_req <= 1'b0;
                    end else if (i_pause) begin
                        r_state     <= StPause;
                        r_recording <= 1'b0;
                    end else if (w_lrc_fall) begin
                        r_state <= StShift;
                        r_cnt   <= '0;
                    end
                end
                StShift: begin
                    if (i_stop) begin
                        r_state     <= StIdle;
                        r_recording <= 1'b0;
                        r_pause_req <= 1'b0;
                    end else begin
                        if (i_pause) begin
                            r_pause_req <= 1'b1;
                        end
                        r_sr  <= w_sr_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_data  <= w_sr_next;
                            r_state <= StWrite;
                            r_valid <= 1'b1;
                        end
                    end
                end
                StWrite: begin
                    // The strobe for this sample is already on the output, so every exit commits it.
                    r_pause_req <= 1'b0;
                    if (r_address == MAX_ADDR) begin
                        r_full      <= 1'b1;
                        r_state     <= StIdle;
                        r_recording <= 1'b0;
                    end else begin
                        r_address <= r_address + 1'b1;
                        if (i_stop) begin
                            r_state     <= StIdle;
                            r_recording <= 1'b0;
                        end else if (r_pause_req || i_pause) begin
                            r_state     <= StPause;
                            r_recording <= 1'b0;
                        end else begin
                            r_state <= StArm;
                        end
                    end
                end
                StPause: begin
                    if (i_stop) begin
                        r_state     <= StIdle;
                        r_pause_req <= 1'b0;
                    end else if (i_start && !i_pause) begin
                        r_state     <= StArm;
                        r_recording <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_recording <= 1'b0;
                end
            endcase
        end
    end

    assign o_address   = r_address;
    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_recording = r_recording;
    assign o_full      = r_full;
endmodule

// File: tb/tb_aud_i2s_recorder.sv
// Directed bench for aud_i2s_recorder: drives 32-slot I2S frames and checks the write strobes.
// A second instance with MAX_ADDR=3 shares the stimulus to exercise the full path.
module tb_aud_i2s_recorder;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, pause, stop, lrc, adcdat;
    logic [19:0] o_address, s_address;
    logic [15:0] o_data, s_data;
    logic        o_valid, o_recording, o_full;
    logic        s_valid, s_recording, s_full;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int det   = 0;
    logic prev_lsb = 1'b0;

    logic [19:0] q_addr[$];
    logic [15:0] q_data[$];
    int          q_cyc[$];
    logic [19:0] sq_addr[$];

    aud_i2s_recorder u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_pause    (pause),
        .i_stop     (stop),
        .i_lrc      (lrc),
        .i_adcdat   (adcdat),
        .o_address  (o_address),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_recording(o_recording),
        .o_full     (o_full)
    );

    aud_i2s_recorder #(
        .MAX_ADDR(20'd3)
    ) u_small (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_pause    (pause),
        .i_stop     (stop),
        .i_lrc      (lrc),
        .i_adcdat   (adcdat),
        .o_address  (s_address),
        .o_data     (s_data),
        .o_valid    (s_valid),
        .o_recording(s_recording),
        .o_full     (s_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log each strobe with the index of the clock edge that ends its cycle.
    always @(negedge clk) begin
        if (o_valid) begin
            q_addr.push_back(o_address);
            q_data.push_back(o_data);
            q_cyc.push_back(cyc + 1);
        end
        if (s_valid) sq_addr.push_back(s_address);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Slot 0: LRC falls, data is the previous right LSB; slots 1..16 carry left MSB..LSB.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int pause_slot, input int stop_slot);
        for (int i = 0; i < 32; i++) begin
            lrc = (i >= 16);
            if (i == 0) adcdat = prev_lsb;
            else if (i <= 16) adcdat = l[16-i];
            else adcdat = r[32-i];
            pause = (i == pause_slot);
            stop  = (i == stop_slot);
            tick();
            if (i == 0) det = cyc;
        end
        pause    = 1'b0;
        stop     = 1'b0;
        prev_lsb = r[0];
    endtask

    task automatic clear_logs();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
        sq_addr.delete();
    endtask

    initial begin
        logic [15:0] exp3[3];
        exp3 = '{16'h0001, 16'h8000, 16'hFFFF};

        // T1: reset with random inputs
        rst = 1'b1;
        start = 1'b0; pause = 1'b0; stop = 1'b0; lrc = 1'b1; adcdat = 1'b0;
        for (int i = 0; i < 100; i++) begin
            start  = 1'($urandom);
            pause  = 1'($urandom);
            stop   = 1'($urandom);
            lrc    = 1'($urandom);
            adcdat = 1'($urandom);
            tick();
            check("reset_outputs", 64'({o_address, o_data, o_valid, o_recording, o_full}), 64'd0);
            check("reset_small", 64'({s_address, s_data, s_valid, s_recording, s_full}), 64'd0);
        end
        check("reset_no_valid", 64'(q_addr.size() + sq_addr.size()), 64'd0);
        start = 1'b0; pause = 1'b0; stop = 1'b0; lrc = 1'b1; adcdat = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        check("idle_not_recording", 64'(o_recording), 64'd0);

        // T2: single sample
        clear_logs();
        pulse_start();
        check("t2_recording", 64'(o_recording), 64'd1);
        send_frame(16'hA5C3, 16'h5A5A, -1, -1);
        check("t2_count", 64'(q_addr.size()), 64'd1);
        check("t2_addr", 64'(q_addr.size() > 0 ? q_addr[0] : 20'hFFFFF), 64'd0);
        check("t2_data", 64'(q_data.size() > 0 ? q_data[0] : 16'h0000), 64'hA5C3);
        check("t2_latency", 64'(q_cyc.size() > 0 ? q_cyc[0] - det : -1), 64'd17);
        check("t2_addr_after", 64'(o_address), 64'd1);
        check("t2_still_armed", 64'(o_recording), 64'd1);

        // T3: three-frame stream; right-half words differ from every left word
        pulse_stop();
        check("t3_stopped", 64'(o_recording), 64'd0);
        clear_logs();
        pulse_start();
        send_frame(16'h0001, 16'h1234, -1, -1);
        send_frame(16'h8000, 16'h4321, -1, -1);
        send_frame(16'hFFFF, 16'h0F0F, -1, -1);
        check("t3_count", 64'(q_addr.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check("t3_addr", 64'(q_addr.size() > i ? q_addr[i] : 20'hFFFFF), 64'(i));
            check("t3_data", 64'(q_data.size() > i ? q_data[i] : 16'h1234), 64'(exp3[i]));
        end
        check("t3_addr_after", 64'(o_address), 64'd3);
        check("t3_not_full", 64'(o_full), 64'd0);

        // T4: pause during frame 2
        pulse_stop();
        clear_logs();
        pulse_start();
        send_frame(16'h1111, 16'hEEEE, -1, -1);
        send_frame(16'h2222, 16'hDDDD, 5, -1);
        check("t4_count_pause", 64'(q_addr.size()), 64'd2);
        check("t4_addr_frame2", 64'(q_addr.size() > 1 ? q_addr[1] : 20'hFFFFF), 64'd1);
        check("t4_data_frame2", 64'(q_data.size() > 1 ? q_data[1] : 16'h0000), 64'h2222);
        check("t4_paused", 64'(o_recording), 64'd0);
        for (int i = 0; i < 5; i++) send_frame(16'h3C3C, 16'hC3C3, -1, -1);
        check("t4_no_writes", 64'(q_addr.size()), 64'd2);
        check("t4_addr_held", 64'(o_address), 64'd2);
        check("t4_data_held", 64'(o_data), 64'h2222);
        pulse_start();
        check("t4_resumed", 64'(o_recording), 64'd1);
        send_frame(16'h4444, 16'hBBBB, -1, -1);
        check("t4_count_resume", 64'(q_addr.size()), 64'd3);
        check("t4_addr_resume", 64'(q_addr.size() > 2 ? q_addr[2] : 20'hFFFFF), 64'd2);
        check("t4_data_resume", 64'(q_data.size() > 2 ? q_data[2] : 16'h0000), 64'h4444);

        // T5: stop during frame 1
        pulse_stop();
        clear_logs();
        pulse_start();
        send_frame(16'h6789, 16'h9876, -1, 8);
        check("t5_no_valid", 64'(q_addr.size()), 64'd0);
        check("t5_not_recording", 64'(o_recording), 64'd0);
        check("t5_addr", 64'(o_address), 64'd0);
        pulse_start();
        send_frame(16'hBEEF, 16'h0000, -1, -1);
        check("t5_count", 64'(q_addr.size()), 64'd1);
        check("t5_addr_restart", 64'(q_addr.size() > 0 ? q_addr[0] : 20'hFFFFF), 64'd0);
        check("t5_data_restart", 64'(q_data.size() > 0 ? q_data[0] : 16'h0000), 64'hBEEF);

        // T6: full path on the MAX_ADDR=3 instance
        pulse_stop();
        clear_logs();
        pulse_start();
        for (int i = 0; i < 6; i++) send_frame(16'(16'h0100 + i), 16'h7777, -1, -1);
        check("t6_count", 64'(sq_addr.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("t6_addr", 64'(sq_addr.size() > i ? sq_addr[i] : 20'hFFFFF), 64'(i));
        end
        check("t6_full", 64'(s_full), 64'd1);
        check("t6_idle", 64'(s_recording), 64'd0);
        check("t6_addr_saturated", 64'(s_address), 64'd3);
        check("t6_last_data", 64'(s_data), 64'h0103);
        check("t6_big_not_full", 64'(o_full), 64'd0);
        pulse_start();
        check("t6_full_cleared", 64'(s_full), 64'd0);
        check("t6_addr_cleared", 64'(s_address), 64'd0);
        send_frame(16'hCAFE, 16'h1111, -1, -1);
        check("t6_count_restart", 64'(sq_addr.size()), 64'd5);
        check("t6_addr_restart", 64'(sq_addr.size() > 4 ? sq_addr[4] : 20'hFFFFF), 64'd0);
        check("t6_data_restart", 64'(s_data), 64'hCAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
